// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed scan driver for a six-digit 7-segment display. Six
//   decoded segment patterns share one segment bus. Each digit gets one slot
//   of SLOT_CYCLES clocks per frame. Every slot starts with DEAD_CYCLES clocks
//   with all digits off, which prevents ghosting. The rest of the slot is
//   split into an ON part and an OFF part by the PWM duty value.
//   All inputs are captured once per frame, at the start of digit 0's slot,
//   so a frame never shows a mix of old and new data.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   segment0..segment5  decoded segment patterns (digit 0 = least significant)
//   blank_mask          bit i = 1 keeps digit i dark
//   duty                brightness; ON width = (duty+1)/8 of the post-dead slot
//   seg_out             shared segment bus (registered)
//   digit_en            digit enables, at most one active (registered)
//   frame_tick          one-cycle pulse after a new frame snapshot is taken
//
// SLOT_CYCLES must be >= DEAD_CYCLES + 8, and DEAD_CYCLES must be >= 1.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned SLOT_CYCLES    = 50000,
    parameter int unsigned DEAD_CYCLES    = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] segment0,
    input  logic [6:0] segment1,
    input  logic [6:0] segment2,
    input  logic [6:0] segment3,
    input  logic [6:0] segment4,
    input  logic [6:0] segment5,
    input  logic [5:0] blank_mask,
    input  logic [2:0] duty,
    output logic [6:0] seg_out,
    output logic [5:0] digit_en,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(SLOT_CYCLES);
    // The extra bits give headroom for (SLOT_CYCLES-DEAD_CYCLES) * 8
    // before the divide by 8.
    localparam int unsigned OW = CW + 4;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [OW-1:0] wide_t;

    localparam cnt_t       CNT_LAST = cnt_t'(SLOT_CYCLES - 1);
    localparam wide_t      DEAD_W   = wide_t'(DEAD_CYCLES);
    localparam wide_t      SPAN_W   = wide_t'(SLOT_CYCLES - DEAD_CYCLES);
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0] DIG_OFF  = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {
        ST_DEAD,
        ST_ON,
        ST_OFF
    } slot_state_e;

    cnt_t        cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  shadow_q [6];
    logic [5:0]  blank_q;
    logic [2:0]  duty_q;
    logic [6:0]  seg_q, seg_d;
    logic [5:0]  dig_q, dig_d;
    logic        tick_q;

    logic        snap;
    wide_t       span_scaled;
    wide_t       on_end;
    slot_state_e state;
    logic [5:0]  onehot;

    // A snapshot is taken at the start of digit 0's slot. The first such edge
    // after reset release also takes one.
    assign snap = (cnt_q == '0) && (idx_q == 3'd0);

    // Slot counter and digit index.
    // NOTE: always_comb assigns every output before any branch. No path can
    // leave a value unassigned, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + cnt_t'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Position inside the slot decides DEAD / ON / OFF. With duty 7 the ON
    // phase runs to the end of the slot, so OFF never occurs.
    always_comb begin
        span_scaled = SPAN_W * (wide_t'(duty_q) + wide_t'(1));
        on_end      = DEAD_W + (span_scaled >> 3);
        state       = ST_OFF;
        if (wide_t'(cnt_q) < DEAD_W) begin
            state = ST_DEAD;
        end else if (wide_t'(cnt_q) < on_end) begin
            state = ST_ON;
        end
    end

    // Output selection. The shadowed pattern passes through unchanged.
    // Only the idle levels depend on polarity.
    always_comb begin
        onehot = 6'b000001 << idx_q;
        seg_d  = SEG_OFF;
        dig_d  = DIG_OFF;
        if (state == ST_ON && !blank_q[idx_q]) begin
            seg_d = shadow_q[idx_q];
            dig_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    // NOTE: Sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge.
    // NOTE: The shadow registers are reset to the idle pattern, so stale data
    // cannot be shown before the first snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= SEG_OFF;
            end
            blank_q <= '0;
            duty_q  <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dig_q  <= dig_d;
            tick_q <= snap;
            if (snap) begin
                shadow_q[0] <= segment0;
                shadow_q[1] <= segment1;
                shadow_q[2] <= segment2;
                shadow_q[3] <= segment3;
                shadow_q[4] <= segment4;
                shadow_q[5] <= segment5;
                blank_q     <= blank_mask;
                duty_q      <= duty;
            end
        end
    end

    assign seg_out    = seg_q;
    assign digit_en   = dig_q;
    assign frame_tick = tick_q;

endmodule
